// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, controller/bus-writer state types and small helpers
package lcd_pkg;

  localparam logic [7:0] CLEAR_DISPLAY   = 8'h01;
  localparam logic [7:0] ENTRY_INC       = 8'h06;
  localparam logic [7:0] DISP_ON_CUR_OFF = 8'h0C;
  localparam logic [7:0] FUNC_2L_8BIT    = 8'h38;
  localparam logic [7:0] LINE1_ADDR      = 8'h80;
  localparam logic [7:0] LINE2_ADDR      = 8'hC0;

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, CHAR, FIN} state_e;

  typedef enum logic [1:0] {WR_IDLE, WR_SETUP, WR_HIGH, WR_WAIT} wr_phase_e;

  // power-up command order: function set, entry mode, display on, clear last
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    return (i == 2'd0) ? FUNC_2L_8BIT : (i == 2'd1) ? ENTRY_INC :
           (i == 2'd2) ? DISP_ON_CUR_OFF : CLEAR_DISPLAY;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: one LCD byte write (setup cycle, enable pulse, post-write wait) behind a start/rdy handshake
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYC  = 50,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       rdy_o,
  output logic       rs_o,
  output logic       en_o,
  output logic [7:0] data_o
);

  localparam int MAXW = max_int(max_int(CLR_WAIT_CYC, CMD_WAIT_CYC), EN_HIGH_CYC);
  localparam int CW   = $clog2(MAXW) + 1;

  wr_phase_e     ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d, last_w;
  logic          rs_q, en_q;
  logic [7:0]    data_q;

  assign last_w = (!rs_q && data_q == CLEAR_DISPLAY) ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
  assign rdy_o  = (ph_q == WR_WAIT) && (cnt_q == last_w);
  assign rs_o   = rs_q;
  assign data_o = data_q;
  assign en_o   = en_q;

  // phase sequencing; a start in the rdy cycle chains the next byte without a gap
  always_comb begin
    ph_d  = ph_q;
    cnt_d = (ph_q == WR_IDLE) ? '0 : cnt_q + 1'b1;
    if (ph_q == WR_SETUP) begin
      ph_d  = WR_HIGH;
      cnt_d = '0;
    end else if (ph_q == WR_HIGH && cnt_q == CW'(EN_HIGH_CYC - 1)) begin
      ph_d  = WR_WAIT;
      cnt_d = '0;
    end else if (rdy_o) begin
      ph_d = WR_IDLE;
    end
    if (start_i) begin
      ph_d  = WR_SETUP;
      cnt_d = '0;
    end
  end

  // phase/counter registers, registered enable and the bus value held until the next start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph_q   <= WR_IDLE;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
      en_q  <= (ph_d == WR_HIGH);
      if (start_i) begin
        rs_q   <= rs_i;
        data_q <= data_i;
      end
    end

endmodule

// File: rtl/lcd_line_arbiter.sv
// lcd_line_arbiter: shares a 16x2 HD44780 LCD between two line writers; define LCD_FIXED_PRIORITY_EN to make requester 0 always win ties
module lcd_line_arbiter
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYC    = 50,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLR_WAIT_CYC   = 100000,
  parameter int POWERUP_CYC    = 2000000,
  parameter int CHARS_PER_LINE = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        req,
  input  logic [1:0]                        line_sel,
  input  logic [7:0]                        char0,
  input  logic [7:0]                        char1,
  output logic [$clog2(CHARS_PER_LINE)-1:0] char_idx,
  output logic [1:0]                        grant,
  output logic [1:0]                        done,
  output logic                              busy,
  output logic                              rs,
  output logic                              rw,
  output logic                              enable,
  output logic [7:0]                        data
);

  localparam int IW = $clog2(CHARS_PER_LINE);
  localparam int PW = $clog2(POWERUP_CYC) + 1;

  state_e        state_q, state_d;
  logic [PW-1:0] pw_q, pw_d;
  logic [1:0]    ii_q, ii_d;
  logic [IW-1:0] idx_q;
  logic          win_q, win_d, busy_q, busy_d, pick, rdy, bw_start, bw_rs;
  logic [1:0]    grant_q, grant_d, done_q, done_d;
  logic [7:0]    bw_data, cur_char;

`ifdef LCD_FIXED_PRIORITY_EN
  assign pick = ~req[0];
`else
  logic last_q;
  assign pick = (&req) ? ~last_q : req[1];
  // remember who was served last so the other requester wins the next tie
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b1;
    else if (state_q == IDLE && |req) last_q <= pick;
`endif

  assign char_idx = (state_q == CHAR && rdy) ? ((idx_q == IW'(CHARS_PER_LINE - 1)) ? '0 : idx_q + 1'b1) : idx_q;
  assign cur_char = win_q ? char1 : char0;
  assign grant    = grant_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign rw       = 1'b0;

  // sequencing of init and line writes; each byte is launched in the cycle the previous one reports rdy
  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    ii_d     = ii_q;
    win_d    = win_q;
    grant_d  = grant_q;
    done_d   = 2'b00;
    busy_d   = busy_q;
    bw_start = 1'b0;
    bw_rs    = 1'b0;
    bw_data  = 8'h00;
    case (state_q)
      PWRUP: begin
        pw_d = pw_q + 1'b1;
        if (pw_q == PW'(POWERUP_CYC - 1)) begin
          state_d  = INIT;
          ii_d     = 2'd0;
          bw_start = 1'b1;
          bw_data  = init_cmd(2'd0);
        end
      end
      INIT: if (rdy) begin
        if (ii_q == 2'd3) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          ii_d     = ii_q + 2'd1;
          bw_start = 1'b1;
          bw_data  = init_cmd(ii_q + 2'd1);
        end
      end
      IDLE: if (|req) begin
        state_d  = ADDR;
        win_d    = pick;
        grant_d  = pick ? 2'b10 : 2'b01;
        busy_d   = 1'b1;
        bw_start = 1'b1;
        bw_data  = line_sel[pick] ? LINE2_ADDR : LINE1_ADDR;
      end
      ADDR: if (rdy) begin
        state_d  = CHAR;
        bw_start = 1'b1;
        bw_rs    = 1'b1;
        bw_data  = cur_char;
      end
      CHAR: if (rdy) begin
        if (idx_q == IW'(CHARS_PER_LINE - 1)) begin
          state_d = FIN;
          grant_d = 2'b00;
          busy_d  = 1'b0;
          done_d  = grant_q;
        end else begin
          bw_start = 1'b1;
          bw_rs    = 1'b1;
          bw_data  = cur_char;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = PWRUP;
    endcase
  end

  // controller state, reset straight back to the power-up wait
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= PWRUP;
      pw_q    <= '0;
      ii_q    <= 2'd0;
      idx_q   <= '0;
      win_q   <= 1'b0;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      ii_q    <= ii_d;
      idx_q   <= char_idx;
      win_q   <= win_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end

  lcd_bus_writer #(
    .EN_HIGH_CYC (EN_HIGH_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_writer (
    .clk    (clk),
    .rst_n  (reset),
    .start_i(bw_start),
    .rs_i   (bw_rs),
    .data_i (bw_data),
    .rdy_o  (rdy),
    .rs_o   (rs),
    .en_o   (enable),
    .data_o (data)
  );

endmodule
